// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE Z store path: store configuration and sequencer state.
package redmule_pkg;

  localparam int unsigned ZStoreAw   = 32;
  localparam int unsigned ZStoreCntW = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } z_store_state_e;

  typedef struct packed {
    logic [ZStoreAw-1:0]   base;
    logic [ZStoreAw-1:0]   row_stride;
    logic [ZStoreAw-1:0]   tile_stride;
    logic [ZStoreCntW-1:0] n_rows;
    logic [ZStoreCntW-1:0] n_tiles;
  } z_store_cfg_t;

endpackage

// File: rtl/redmule_z_store_fifo.sv
// Small decoupling FIFO holding {data, strobe} Z words; head visible combinationally.
module redmule_z_store_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/redmule_z_store_sequencer.sv
// Turns a stream of strobed Z columns into strided row/tile memory writes over a req/gnt port.
module redmule_z_store_sequencer
  import redmule_pkg::*;
#(
  parameter int unsigned DW        = 288,
  parameter int unsigned AW        = ZStoreAw,
  parameter int unsigned CntW      = ZStoreCntW,
  parameter int unsigned FifoDepth = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            start_i,
  input  logic [AW-1:0]   base_addr_i,
  input  logic [AW-1:0]   row_stride_i,
  input  logic [AW-1:0]   tile_stride_i,
  input  logic [CntW-1:0] n_rows_i,
  input  logic [CntW-1:0] n_tiles_i,
  input  logic            z_valid_i,
  input  logic [DW-1:0]   z_data_i,
  input  logic [DW/8-1:0] z_strb_i,
  output logic            z_ready_o,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic            mem_we_o,
  output logic            busy_o,
  output logic            tile_done_o,
  output logic            done_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned FW = DW + SW;

  z_store_state_e    state_q;
  z_store_cfg_t      cfg_q;
  logic [2*CntW-1:0] accepted_q, total_q;
  logic [CntW-1:0]   row_q, tile_q;
  logic [AW-1:0]     row_off_q, tile_off_q;

  logic [FW-1:0] fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [DW-1:0] head_data;
  logic [SW-1:0] head_strb;
  logic          run, head_live, push, pop, last_row, last_tile;

  redmule_z_store_fifo #(
    .Width (FW),
    .Depth (FifoDepth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push),
    .wdata_i ({z_data_i, z_strb_i}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_data = fifo_rdata[FW-1:SW];
  assign head_strb = fifo_rdata[SW-1:0];

  assign run       = (state_q == RUN);
  assign busy_o    = run;
  assign z_ready_o = run & ~fifo_full & (accepted_q < total_q);
  assign push      = z_valid_i & z_ready_o;

  // A head with no enabled bytes still consumes its row, just without a request.
  assign head_live = run & ~fifo_empty;
  assign mem_req_o = head_live & (|head_strb);
  assign pop       = head_live & (~(|head_strb) | mem_gnt_i);

  assign mem_we_o    = mem_req_o;
  assign mem_addr_o  = cfg_q.base + tile_off_q + row_off_q;
  assign mem_wdata_o = mem_req_o ? head_data : '0;
  assign mem_be_o    = mem_req_o ? head_strb : '0;

  assign last_row  = (row_q == cfg_q.n_rows - 1'b1);
  assign last_tile = (tile_q == cfg_q.n_tiles - 1'b1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      accepted_q  <= '0;
      total_q     <= '0;
      row_q       <= '0;
      tile_q      <= '0;
      row_off_q   <= '0;
      tile_off_q  <= '0;
      tile_done_o <= 1'b0;
      done_o      <= 1'b0;
    end else if (clear_i) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      accepted_q  <= '0;
      total_q     <= '0;
      row_q       <= '0;
      tile_q      <= '0;
      row_off_q   <= '0;
      tile_off_q  <= '0;
      tile_done_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      tile_done_o <= 1'b0;
      done_o      <= 1'b0;
      if (push) accepted_q <= accepted_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            cfg_q       <= '{base: base_addr_i, row_stride: row_stride_i,
                             tile_stride: tile_stride_i, n_rows: n_rows_i,
                             n_tiles: n_tiles_i};
            accepted_q  <= '0;
            total_q     <= {{CntW{1'b0}}, n_rows_i} * {{CntW{1'b0}}, n_tiles_i};
            row_q       <= '0;
            tile_q      <= '0;
            row_off_q   <= '0;
            tile_off_q  <= '0;
            if ((n_rows_i == '0) || (n_tiles_i == '0)) begin
              state_q <= DONE;
              done_o  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (pop) begin
            if (last_row) begin
              row_q       <= '0;
              row_off_q   <= '0;
              tile_off_q  <= tile_off_q + cfg_q.tile_stride;
              tile_q      <= tile_q + 1'b1;
              tile_done_o <= 1'b1;
              if (last_tile) begin
                state_q <= DONE;
                done_o  <= 1'b1;
              end
            end else begin
              row_q     <= row_q + 1'b1;
              row_off_q <= row_off_q + cfg_q.row_stride;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
